// File: rtl/pwm_capture_if.sv
// Register bus for pwm_capture: one write port and one combinational read port.
// The master drives the addresses and write data; the slave returns read_data.
interface pwm_capture_if;
  logic        we_i;
  logic [31:0] write_addr;
  logic [31:0] write_data;
  logic [31:0] read_addr;
  logic [31:0] read_data;

  modport master (
    output we_i,
    output write_addr,
    output write_data,
    output read_addr,
    input  read_data
  );

  modport slave (
    input  we_i,
    input  write_addr,
    input  write_data,
    input  read_addr,
    output read_data
  );
endinterface

// File: rtl/pwm_capture.sv
// Four-channel PWM period/high-time capture with a memory-mapped register bank.
// Each channel synchronises its input, then measures it between successive rising edges.
module pwm_capture #(
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    pwm_in,
  pwm_capture_if.slave  bus
);

  localparam logic [31:0] ADDR_PERIOD0 = 32'h0020_0000;
  localparam logic [31:0] ADDR_PERIOD1 = 32'h0021_0000;
  localparam logic [31:0] ADDR_PERIOD2 = 32'h0022_0000;
  localparam logic [31:0] ADDR_PERIOD3 = 32'h0023_0000;
  localparam logic [31:0] ADDR_CTRL    = 32'h0024_0000;
  localparam logic [31:0] ADDR_STATUS  = 32'h0025_0000;
  localparam logic [31:0] ADDR_HIGH0   = 32'h0030_0000;
  localparam logic [31:0] ADDR_HIGH1   = 32'h0031_0000;
  localparam logic [31:0] ADDR_HIGH2   = 32'h0032_0000;
  localparam logic [31:0] ADDR_HIGH3   = 32'h0033_0000;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_MEAS = 2'd2
  } state_t;

  state_t           r_state    [4];
  logic [CNT_W-1:0] r_cnt      [4];
  logic [CNT_W-1:0] r_high_lat [4];
  logic [CNT_W-1:0] r_period   [4];
  logic [CNT_W-1:0] r_high     [4];

  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] r_hist;
  logic [3:0] r_ctrl;
  logic [3:0] r_valid;
  logic [3:0] r_ovf;

  logic [3:0] w_rise;
  logic [3:0] w_fall;
  logic [3:0] w_cap;
  logic [3:0] w_ovf_set;
  logic       w_ctrl_we;
  logic       w_stat_we;
  logic [7:0] w_clr;
  logic       w_unused;

  function automatic logic [31:0] zext(input logic [CNT_W-1:0] v);
    logic [31:0] r;
    r = 32'h0000_0000;
    r[CNT_W-1:0] = v;
    return r;
  endfunction

  assign w_rise    = r_sync2 & ~r_hist;
  assign w_fall    = ~r_sync2 & r_hist;
  assign w_ctrl_we = bus.we_i && (bus.write_addr == ADDR_CTRL);
  assign w_stat_we = bus.we_i && (bus.write_addr == ADDR_STATUS);
  assign w_clr     = w_stat_we ? bus.write_data[7:0] : 8'h00;
  assign w_unused  = ^bus.write_data[31:8];

  // Capture and overflow events feed STATUS in the same cycle the FSM acts on them.
  always_comb begin
    w_cap     = 4'b0000;
    w_ovf_set = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      if (r_ctrl[n] && (r_state[n] == S_MEAS)) begin
        w_cap[n]     = w_rise[n];
        w_ovf_set[n] = !w_rise[n] && (r_cnt[n] == CNT_MAX);
      end else begin
        w_cap[n]     = 1'b0;
        w_ovf_set[n] = 1'b0;
      end
    end
  end

  // Two-flop synchronizer followed by a history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
      r_hist  <= 4'b0000;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  // Per-channel measurement FSM; a cleared enable overrides every state.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (rst) begin
        r_state[n]    <= S_IDLE;
        r_cnt[n]      <= CNT_ZERO;
        r_high_lat[n] <= CNT_ZERO;
        r_period[n]   <= CNT_ZERO;
        r_high[n]     <= CNT_ZERO;
      end else if (!r_ctrl[n]) begin
        r_state[n]    <= S_IDLE;
        r_cnt[n]      <= CNT_ZERO;
        r_high_lat[n] <= CNT_ZERO;
      end else begin
        case (r_state[n])
          S_IDLE: begin
            r_state[n] <= S_ARM;
          end
          S_ARM: begin
            if (w_rise[n]) begin
              r_state[n] <= S_MEAS;
              r_cnt[n]   <= CNT_ONE;
            end
          end
          S_MEAS: begin
            if (w_rise[n]) begin
              r_period[n] <= r_cnt[n];
              r_high[n]   <= r_high_lat[n];
              r_cnt[n]    <= CNT_ONE;
            end else if (r_cnt[n] == CNT_MAX) begin
              // Counter saturated: drop the measurement and wait for a fresh edge.
              r_state[n] <= S_ARM;
              r_cnt[n]   <= CNT_ZERO;
            end else begin
              r_cnt[n] <= r_cnt[n] + CNT_ONE;
              if (w_fall[n]) begin
                r_high_lat[n] <= r_cnt[n];
              end
            end
          end
          default: begin
            r_state[n]    <= S_IDLE;
            r_cnt[n]      <= CNT_ZERO;
            r_high_lat[n] <= CNT_ZERO;
          end
        endcase
      end
    end
  end

  // CTRL and STATUS; a hardware set outranks a write-one-to-clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl  <= 4'b0000;
      r_valid <= 4'b0000;
      r_ovf   <= 4'b0000;
    end else begin
      if (w_ctrl_we) begin
        r_ctrl <= bus.write_data[3:0];
      end
      r_valid <= (r_valid & ~w_clr[3:0]) | w_cap;
      r_ovf   <= (r_ovf & ~w_clr[7:4]) | w_ovf_set;
    end
  end

  // Combinational read mux with full address decode.
  always_comb begin
    bus.read_data = 32'h0000_0000;
    case (bus.read_addr)
      ADDR_PERIOD0: bus.read_data = zext(r_period[0]);
      ADDR_PERIOD1: bus.read_data = zext(r_period[1]);
      ADDR_PERIOD2: bus.read_data = zext(r_period[2]);
      ADDR_PERIOD3: bus.read_data = zext(r_period[3]);
      ADDR_HIGH0:   bus.read_data = zext(r_high[0]);
      ADDR_HIGH1:   bus.read_data = zext(r_high[1]);
      ADDR_HIGH2:   bus.read_data = zext(r_high[2]);
      ADDR_HIGH3:   bus.read_data = zext(r_high[3]);
      ADDR_CTRL:    bus.read_data = {28'h000_0000, r_ctrl};
      ADDR_STATUS:  bus.read_data = {24'h00_0000, r_ovf, r_valid};
      default:      bus.read_data = 32'h0000_0000;
    endcase
  end

endmodule
